// File: rtl/ac97_pkg.sv
// AC-link frame geometry and receiver state encoding shared by the frame receiver.
package ac97_pkg;
  localparam int FRAME_BITS = 256;
  localparam int SLOT0_BITS = 16;
  localparam int SLOT_BITS  = 20;
  localparam int SLOT1_OFS  = 16;
  localparam int SLOT2_OFS  = 36;
  localparam int SLOT3_OFS  = 56;
  localparam int SLOT4_OFS  = 76;

  typedef enum logic [1:0] {ST_HUNT, ST_SLOT0, ST_DATA} ac97_state_e;

  // First frame bit index of captured slot k (1..4).
  function automatic logic [7:0] slot_ofs(input int k);
    case (k)
      1:       return 8'(SLOT1_OFS);
      2:       return 8'(SLOT2_OFS);
      3:       return 8'(SLOT3_OFS);
      default: return 8'(SLOT4_OFS);
    endcase
  endfunction
endpackage

// File: rtl/ac97_slot_shifter.sv
// MSB-first serial-in shadow register for one AC-link slot.
module ac97_slot_shifter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_data
);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    o_data <= '0;
    else if (i_en) o_data <= {o_data[W-2:0], i_bit};
  end
endmodule

// File: rtl/ac97_frame_receiver.sv
// AC-link input frame receiver: locks to sync, shadows slots 0-4, publishes
// tags, status and PCM together one cycle after the last frame bit.
module ac97_frame_receiver
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 sync,
  input  logic                 sdata_in,
  output logic                 frame_valid,
  output logic                 codec_ready,
  output logic [11:0]          slot_tags,
  output logic                 status_valid,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 pcm_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 framing_error
);
  localparam logic [7:0] LAST_BIT  = 8'(FRAME_BITS - 1);
  localparam logic [7:0] SLOT0_END = 8'(SLOT0_BITS - 1);

  ac97_state_e      r_state;
  logic [7:0]       r_cnt;
  logic             r_sync_q;
  logic             w_rise;
  logic             w_bit0;
  logic [4:0]       w_en;
  logic [4:0][19:0] w_slot;
  logic             w_unused_bits;

  assign w_rise = sync & ~r_sync_q;
  // Frame bit 0 is either a fresh lock from HUNT or the expected rise at wrap.
  assign w_bit0 = w_rise && ((r_state == ST_HUNT) ||
                             (r_state == ST_DATA && r_cnt == 8'd0));
  assign w_en[0] = w_bit0 || (r_state == ST_SLOT0);

  for (genvar k = 1; k < 5; k++) begin : g_en
    localparam logic [7:0] LO = slot_ofs(k);
    localparam logic [7:0] HI = LO + 8'(SLOT_BITS);
    assign w_en[k] = (r_state == ST_DATA) && (r_cnt >= LO) && (r_cnt < HI);
  end

  for (genvar g = 0; g < 5; g++) begin : g_slot
    ac97_slot_shifter #(.W(SLOT_BITS)) u_sh (
      .clk    (clk),
      .rst_b  (rst_b),
      .i_en   (w_en[g]),
      .i_bit  (sdata_in),
      .o_data (w_slot[g])
    );
  end

  assign w_unused_bits = ^{w_slot[0][19:16], w_slot[0][2:0], w_slot[1][19],
                           w_slot[1][11:0], w_slot[2][3:0], w_slot[3], w_slot[4]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= ST_HUNT;
      r_cnt         <= '0;
      r_sync_q      <= 1'b1;
      frame_valid   <= 1'b0;
      codec_ready   <= 1'b0;
      slot_tags     <= '0;
      status_valid  <= 1'b0;
      status_addr   <= '0;
      status_data   <= '0;
      pcm_valid     <= 1'b0;
      pcm_left      <= '0;
      pcm_right     <= '0;
      framing_error <= 1'b0;
    end else begin
      r_sync_q      <= sync;
      frame_valid   <= 1'b0;
      status_valid  <= 1'b0;
      pcm_valid     <= 1'b0;
      framing_error <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_rise) begin
            r_state <= ST_SLOT0;
            r_cnt   <= 8'd1;
          end
        end
        ST_SLOT0: begin
          if (!sync) begin
            framing_error <= 1'b1;
            r_state       <= ST_HUNT;
            r_cnt         <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == SLOT0_END) r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_cnt == 8'd0) begin
            if (w_rise) begin
              r_state <= ST_SLOT0;
              r_cnt   <= 8'd1;
            end else begin
              framing_error <= 1'b1;
              r_state       <= ST_HUNT;
            end
          end else if (sync) begin
            framing_error <= 1'b1;
            r_state       <= ST_HUNT;
            r_cnt         <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            // Slots 0-4 finished long ago; publish the whole frame at once.
            if (r_cnt == LAST_BIT) begin
              frame_valid <= 1'b1;
              codec_ready <= w_slot[0][15];
              slot_tags   <= w_slot[0][14:3];
              if (w_slot[0][14] && w_slot[0][13]) begin
                status_valid <= 1'b1;
                status_addr  <= w_slot[1][18:12];
                status_data  <= w_slot[2][19:4];
              end
              if (w_slot[0][12] && w_slot[0][11]) begin
                pcm_valid <= 1'b1;
                pcm_left  <= w_slot[3][19 -: PCM_WIDTH];
                pcm_right <= w_slot[4][19 -: PCM_WIDTH];
              end
            end
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/ac97_frame_receiver.md
AC97_FRAME_RECEIVER -- requirements
Module: ac97_frame_receiver

Interface
REQ-001 SHALL have parameter PCM_WIDTH, default 20, PCM sample width output; legal values 1..20; keeps the slot MSBs.
REQ-002 SHALL have port clk  input  1  AC-link bit clock (buffered bit_clk); the only clock.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sync  input  1  AC-link frame sync, as driven by the controller.
REQ-005 SHALL have port sdata_in  input  1  serial data from the codec.
REQ-006 SHALL have port frame_valid  output  1  one-cycle pulse per completed frame.
REQ-007 SHALL have port codec_ready  output  1  slot 0 bit 15 of the last complete frame.
REQ-008 SHALL have port slot_tags  output  12  slot 0 bits 14:3 of the last complete frame (bit 11 = slot 1 valid).
REQ-009 SHALL have port status_valid  output  1  one-cycle pulse when the completed frame tagged slots 1 and 2 valid.
REQ-010 SHALL have port status_addr  output  7  slot 1 bits 18:12.
REQ-011 SHALL have port status_data  output  16  slot 2 bits 19:4.
REQ-012 SHALL have port pcm_valid  output  1  one-cycle pulse when the completed frame tagged slots 3 and 4 valid.
REQ-013 SHALL have ports pcm_left and pcm_right  output  PCM_WIDTH each  slot 3 and slot 4 bits 19:(20-PCM_WIDTH).
REQ-014 SHALL have port framing_error  output  1  one-cycle pulse on a sync violation.

Function
REQ-015 SHALL sample sync and sdata_in on the rising edge of clk; bits arrive MSB first.
REQ-016 SHALL define frame bit 0 as the sdata_in sample taken in the first cycle where sync is high after a low sample.
REQ-017 SHALL use frame layout: bits 0-15 slot 0, then slots 1-12 at 20 bits each, 256 bits total.
REQ-018 SHALL implement FSM HUNT -> SLOT0 (bit 0 seen) -> DATA (bit 16) -> SLOT0 (next sync rise at bit 256) or HUNT.
REQ-019 SHALL hold an 8-bit bit counter that is 0 at frame bit 0 and wraps 255 -> 0.
REQ-020 SHALL, in HUNT, ignore sdata_in and assert no output pulses.
REQ-021 SHALL pulse framing_error and enter HUNT in three cases: sync low during bits 1-15; sync high during bits 16-255; sync rise expected at wrap but not seen.
REQ-022 SHALL treat a sync rise exactly at the wrap as frame bit 0 of the next frame, with no error.
REQ-023 SHALL discard an errored frame: no frame_valid, status_valid or pcm_valid, and data outputs keep their previous values.
REQ-024 SHALL shift bits into shadow registers and copy them to all data outputs together, one cycle after bit 255 is sampled.
REQ-025 SHALL assert frame_valid in that same cycle, with status_valid and pcm_valid gated by the captured tags.
REQ-026 SHALL update status_addr/status_data only when slots 1 and 2 are tagged, and pcm_left/pcm_right only when slots 3 and 4 are tagged.
REQ-027 SHALL update codec_ready and slot_tags on every valid frame.
REQ-028 SHALL have a latency of exactly 1 cycle from sampling bit 255 to the frame_valid pulse, overlapping bit 0 of the next frame.

Reset
REQ-029 SHALL, while rst_b is low, force state HUNT, counter 0, all outputs and shadow registers 0.
REQ-030 SHALL abandon a partial frame when reset asserts mid-frame; after release, reception resumes at the next sync rise.

Structure
REQ-031 SHALL place frame constants in shared package ac97_pkg: FRAME_BITS=256, SLOT0_BITS=16, SLOT_BITS=20, and the bit offsets of slots 1-4.
REQ-032 SHALL place the FSM state encoding in ac97_pkg.
REQ-033 SHALL use one sub-module, ac97_slot_shifter (20-bit shift register with load enable), instantiated per captured slot.

Verification
REQ-034 SHALL pass: valid frame with tags 0xF800 (ready, slots 1-4), addr 0x26, data 0x000F, L=0x12345, R=0xABCDE -> frame_valid, status_valid and pcm_valid pulse once; outputs match with PCM_WIDTH=20.
REQ-035 SHALL pass: frame with tags 0x9800 (ready, slots 3-4 only) -> pcm_valid pulses, status_valid stays 0, status outputs unchanged.
REQ-036 SHALL pass: sync dropped at bit 8 -> framing_error pulses, no frame_valid; next clean frame is accepted.
REQ-037 SHALL pass: sync held low at bit 256 -> framing_error, HUNT; recovery on the next sync rise.
REQ-038 SHALL pass: rst_b low at bit 100, then released -> all outputs 0; first complete frame after release is captured correctly.
REQ-039 SHALL pass: 1000 back-to-back frames with random data, PCM_WIDTH=18 -> exactly 1000 frame_valid pulses, pcm_left equals slot bits 19:2.
